btb_ctrl: RTL and testbench
===========================

# btb_ctrl

Controller for the branch target buffer (BTB) in the branch-prediction stage. It owns an array of `ENTRY_NUM` direct-mapped target entries and serves three users of that shared storage:
- the fetch-side lookup port;
- the execute-side update port, with a valid/ready handshake;
- a full-array flush sequencer, used on context switch and on the `cache`/`sync` flush path.

It arbitrates all writes to the entry array and guarantees that lookups never hit on stale data during a flush.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, PC/target width.
- `INDEX_WIDTH`, 6, index bits; `ENTRY_NUM` = 2^`INDEX_WIDTH`.
- `TAG_WIDTH`, `ADDR_WIDTH`-`INDEX_WIDTH`-2, stored PC tag width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `lookup_pc`  in  `ADDR_WIDTH`  fetch PC to predict.
- `lookup_hit`  out  1  registered hit for the PC sampled at the previous edge.
- `lookup_is_jump`  out  1  hit entry is an unconditional jump.
- `lookup_target`  out  `ADDR_WIDTH`  predicted target.
- `upd_valid`  in  1  update request.
- `upd_ready`  out  1  update accepted this cycle.
- `upd_pc`  in  `ADDR_WIDTH`  branch PC.
- `upd_target`  in  `ADDR_WIDTH`  resolved target.
- `upd_is_jump`  in  1  unconditional-jump flag.
- `upd_invalidate`  in  1  1 = remove the entry instead of installing it.
- `flush_req`  in  1  single-cycle pulse requesting a full invalidation.
- `flush_busy`  out  1  flush sweep in progress.

## Operation
- Address split: index = pc[`INDEX_WIDTH`+1:2], tag = pc[`ADDR_WIDTH`-1:`INDEX_WIDTH`+2]. The low 2 bits are ignored.
- Each entry holds `valid`, `is_jump`, `tag` and `target`, and is written only through a per-entry write enable driven by this block.
- Lookup: hit = entry[index].valid && entry[index].tag == tag.
  - `lookup_is_jump` and `lookup_target` are the entry fields when hit=1, and 0 when hit=0.
- Install (upd_invalidate=0): entry[index] is overwritten with {1, upd_is_jump, tag, upd_target}, whatever it held before.
- Invalidate (upd_invalidate=1): entry[index].valid is cleared only if the stored tag matches; otherwise the array is unchanged.
- FSM states:
  - IDLE → FLUSH on `flush_req`, with the counter set to 0.
  - FLUSH: clears entry[counter].valid each cycle and increments the counter. After clearing entry `ENTRY_NUM`-1 it returns to IDLE.
  - `flush_req` while in FLUSH restarts the sweep with the counter at 0.
- Arbitration:
  - `upd_ready` = (state==IDLE) && !`flush_req`. Flush beats update.
  - An update is not buffered; the requester holds `upd_valid` and its data until ready.
- During FLUSH, and in the cycle `flush_req` is sampled, the registered `lookup_hit` is forced to 0.

## Timing
- Reset (async, `rst`=1):
  - all entries have valid, is_jump, tag and target = 0;
  - state IDLE, counter 0;
  - `lookup_hit`, `lookup_is_jump`, `lookup_target` = 0;
  - `flush_busy` = 0; `upd_ready` = 1 once `rst` is released, provided `flush_req`=0.
- Reset asserted mid-flush aborts the sweep immediately; all entries are invalid after reset.
- Lookup latency is 1 cycle: `lookup_pc` sampled at edge N produces output valid after edge N.
- Update: written at the edge where `upd_valid`&&`upd_ready`.
  - A lookup of the same index sampled at that same edge returns the old contents (read-before-write).
  - A lookup sampled at the next edge sees the new contents.
- Flush: `flush_req` sampled at edge E.
  - `flush_busy`=1 from after E until after edge E+`ENTRY_NUM`.
  - Entry k is cleared at edge E+1+k.
  - Total duration is `ENTRY_NUM` cycles of busy.
- `flush_req` and `upd_valid` in the same cycle: the update is not accepted, and the flush starts.

## Structure
- Shared package `bp_pkg`: BTB entry struct {valid, is_jump, tag, target}, `INDEX_WIDTH`/`TAG_WIDTH` defaults, FSM state enum {IDLE, FLUSH}.
- Sub-module `btb_entry`: one storage line with async reset, `write_en`, and a separate `clear_valid` input. It is instantiated `ENTRY_NUM` times by a generate loop.
- The controller holds the FSM, flush counter, write-enable decode, lookup mux and output registers.

## Test plan
- Reset, then lookup 0x0000_1000 → `lookup_hit`=0, target=0, `upd_ready`=1, `flush_busy`=0.
- Install pc=0x0000_1004, target=0x0000_2000, is_jump=1 → the next lookup of 0x0000_1004 gives hit=1, is_jump=1, target=0x0000_2000. A lookup of 0x0000_2004 (same index, different tag) gives hit=0.
- Lookup and install of the same pc at the same edge → the first result is hit=0; the following cycle gives hit=1.
- Invalidate with a mismatching tag → entry unchanged, still hits. Invalidate with the matching tag → next lookup hit=0.
- Fill 4 entries, pulse `flush_req` with `upd_valid`=1 asserted → `upd_ready`=0 for 65 cycles, `flush_busy`=1 for exactly 64 cycles, all lookups miss afterwards. The held update is accepted in the first IDLE cycle.
- Assert `rst` at flush count 20, release, install one entry → it hits, `flush_busy`=0, and all other entries miss.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared definitions for the branch-prediction stage: BTB geometry
// defaults, the BTB entry layout and the BTB controller state encoding.
package bp_pkg;

    localparam int BP_ADDR_WIDTH  = 32;
    localparam int BP_INDEX_WIDTH = 6;
    localparam int BP_TAG_WIDTH   = BP_ADDR_WIDTH - BP_INDEX_WIDTH - 2;

    // One BTB line as seen by software models and debug views.
    typedef struct packed {
        logic                     valid;
        logic                     is_jump;
        logic [BP_TAG_WIDTH-1:0]  tag;
        logic [BP_ADDR_WIDTH-1:0] target;
    } btb_entry_t;

    // Controller sequencing: normal service, or full-array invalidation sweep.
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } btb_state_e;

endpackage

// File: rtl/btb_entry.sv
// Single BTB storage line. A write installs a complete valid entry; the
// separate clear input drops only the valid bit so invalidation never has
// to drive tag or target.
module btb_entry
    import bp_pkg::*;
#(
    parameter int ADDR_WIDTH = BP_ADDR_WIDTH,
    parameter int TAG_WIDTH  = BP_TAG_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  write_en_i,
    input  logic                  clear_valid_i,
    input  logic                  is_jump_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    input  logic [ADDR_WIDTH-1:0] target_i,
    output logic                  valid_o,
    output logic                  is_jump_o,
    output logic [TAG_WIDTH-1:0]  tag_o,
    output logic [ADDR_WIDTH-1:0] target_o
);

    logic                  valid_q;
    logic                  is_jump_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [ADDR_WIDTH-1:0] target_q;

    // Line storage: install wins over clear (the controller never asserts both).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            is_jump_q <= 1'b0;
            tag_q     <= '0;
            target_q  <= '0;
        end else if (write_en_i) begin
            valid_q   <= 1'b1;
            is_jump_q <= is_jump_i;
            tag_q     <= tag_i;
            target_q  <= target_i;
        end else if (clear_valid_i) begin
            valid_q   <= 1'b0;
        end
    end

    assign valid_o   = valid_q;
    assign is_jump_o = is_jump_q;
    assign tag_o     = tag_q;
    assign target_o  = target_q;

endmodule

// File: rtl/btb_ctrl.sv
// BTB controller: owns the direct-mapped entry array, serves the fetch
// lookup port, the execute update port and the full-array flush sweep,
// and suppresses hits while a flush is pending or running.
module btb_ctrl
    import bp_pkg::*;
#(
    parameter int ADDR_WIDTH  = BP_ADDR_WIDTH,
    parameter int INDEX_WIDTH = BP_INDEX_WIDTH,
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  lookup_hit,
    output logic                  lookup_is_jump,
    output logic [ADDR_WIDTH-1:0] lookup_target,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_is_jump,
    input  logic                  upd_invalidate,
    input  logic                  flush_req,
    output logic                  flush_busy
);

    localparam int ENTRY_NUM = 1 << INDEX_WIDTH;

    // Update handshake: a request transfers at a rising edge where
    // upd_valid && upd_ready; nothing is buffered, so the requester keeps
    // upd_valid and all upd_* fields stable until that edge.

    btb_state_e             state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic                   flush_clr;

    logic [ENTRY_NUM-1:0]   ent_valid;
    logic [ENTRY_NUM-1:0]   ent_jump;
    logic [TAG_WIDTH-1:0]   ent_tag    [ENTRY_NUM];
    logic [ADDR_WIDTH-1:0]  ent_target [ENTRY_NUM];

    logic [ENTRY_NUM-1:0]   we;
    logic [ENTRY_NUM-1:0]   clr;

    logic [INDEX_WIDTH-1:0] upd_idx;
    logic [TAG_WIDTH-1:0]   upd_tag;
    logic                   upd_fire;

    logic [INDEX_WIDTH-1:0] lk_idx;
    logic [TAG_WIDTH-1:0]   lk_tag;
    logic                   hit_d, hit_q;
    logic                   is_jump_d, is_jump_q;
    logic [ADDR_WIDTH-1:0]  target_d, target_q;

    // The two low PC bits carry no information for a word-aligned BTB.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign upd_idx   = upd_pc[INDEX_WIDTH+1:2];
    assign upd_tag   = upd_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign lk_idx    = lookup_pc[INDEX_WIDTH+1:2];
    assign lk_tag    = lookup_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];

    // A pending flush outranks any update.
    assign upd_ready = (state_q == IDLE) && !flush_req;
    assign upd_fire  = upd_valid && upd_ready;

    // State register and sweep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a flush request (re)starts the sweep at entry 0; the sweep
    // clears one entry per cycle and ends after the last index.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                flush_clr = 1'b1;
                if (flush_req) begin
                    cnt_d = '0;
                end else if (&cnt_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + INDEX_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Per-entry write/clear decode: install, tag-qualified invalidate, sweep.
    always_comb begin
        we  = '0;
        clr = '0;
        if (upd_fire && !upd_invalidate) begin
            we[upd_idx] = 1'b1;
        end
        if (upd_fire && upd_invalidate && (ent_tag[upd_idx] == upd_tag)) begin
            clr[upd_idx] = 1'b1;
        end
        if (flush_clr) begin
            clr[cnt_q] = 1'b1;
        end
    end

    for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_entry
        btb_entry #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH)
        ) u_entry (
            .clk_i         (clk),
            .rst_i         (rst),
            .write_en_i    (we[g]),
            .clear_valid_i (clr[g]),
            .is_jump_i     (upd_is_jump),
            .tag_i         (upd_tag),
            .target_i      (upd_target),
            .valid_o       (ent_valid[g]),
            .is_jump_o     (ent_jump[g]),
            .tag_o         (ent_tag[g]),
            .target_o      (ent_target[g])
        );
    end

    // Lookup mux: reads pre-edge array contents; misses return all-zero
    // fields, and any flush in flight or just requested forces a miss.
    always_comb begin
        hit_d     = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag)
                    && (state_q == IDLE) && !flush_req;
        is_jump_d = 1'b0;
        target_d  = '0;
        if (hit_d) begin
            is_jump_d = ent_jump[lk_idx];
            target_d  = ent_target[lk_idx];
        end
    end

    // Registered lookup result, one cycle after the PC is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q     <= 1'b0;
            is_jump_q <= 1'b0;
            target_q  <= '0;
        end else begin
            hit_q     <= hit_d;
            is_jump_q <= is_jump_d;
            target_q  <= target_d;
        end
    end

    assign lookup_hit     = hit_q;
    assign lookup_is_jump = is_jump_q;
    assign lookup_target  = target_q;
    assign flush_busy     = (state_q == FLUSH);

endmodule

// File: tb/tb_btb_ctrl.sv
// Testbench for btb_ctrl: directed scenarios plus randomized traffic,
// all checked against a behavioural array model of the BTB.
module tb_btb_ctrl;
    import bp_pkg::*;

    localparam int AW = 32;
    localparam int IW = 6;
    localparam int TW = AW - IW - 2;
    localparam int N  = 1 << IW;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] lookup_pc;
    logic          lookup_hit;
    logic          lookup_is_jump;
    logic [AW-1:0] lookup_target;
    logic          upd_valid;
    logic          upd_ready;
    logic [AW-1:0] upd_pc;
    logic [AW-1:0] upd_target;
    logic          upd_is_jump;
    logic          upd_invalidate;
    logic          flush_req;
    logic          flush_busy;

    always #5 clk = ~clk;

    btb_ctrl #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .lookup_pc      (lookup_pc),
        .lookup_hit     (lookup_hit),
        .lookup_is_jump (lookup_is_jump),
        .lookup_target  (lookup_target),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_is_jump    (upd_is_jump),
        .upd_invalidate (upd_invalidate),
        .flush_req      (flush_req),
        .flush_busy     (flush_busy)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    btb_entry_t m_ent [N];
    int         fl_left;   // flush cycles still to run
    int         fl_pos;    // next entry the sweep clears

    function automatic int idx_of(logic [AW-1:0] pc);
        return int'(pc[IW+1:2]);
    endfunction

    function automatic logic [TW-1:0] tag_of(logic [AW-1:0] pc);
        return pc[AW-1:IW+2];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ent[i] = '0;
        fl_left = 0;
        fl_pos  = 0;
    endtask

    // One clock cycle: predicts this edge's lookup result and ready from the
    // model, applies the model's effects of the edge, then advances the DUT.
    task automatic tick(output logic e_hit, output logic e_jump,
                        output logic [AW-1:0] e_tgt,
                        output logic e_ready, output logic a_ready);
        btb_entry_t e;
        int         ui;
        #1;
        a_ready = upd_ready;
        e_ready = (fl_left == 0) && !flush_req;
        e       = m_ent[idx_of(lookup_pc)];
        e_hit   = e.valid && (e.tag == tag_of(lookup_pc)) && (fl_left == 0) && !flush_req;
        e_jump  = e_hit ? e.is_jump : 1'b0;
        e_tgt   = e_hit ? e.target : '0;
        if (upd_valid && e_ready) begin
            ui = idx_of(upd_pc);
            if (!upd_invalidate) begin
                m_ent[ui].valid   = 1'b1;
                m_ent[ui].is_jump = upd_is_jump;
                m_ent[ui].tag     = tag_of(upd_pc);
                m_ent[ui].target  = upd_target;
            end else if (m_ent[ui].tag == tag_of(upd_pc)) begin
                m_ent[ui].valid = 1'b0;
            end
        end
        if (flush_req) begin
            fl_pos  = 0;
            fl_left = N;
        end else if (fl_left > 0) begin
            m_ent[fl_pos].valid = 1'b0;
            fl_pos++;
            fl_left--;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_upd(logic v, logic [AW-1:0] pc, logic [AW-1:0] tgt,
                             logic jmp, logic inv);
        upd_valid      = v;
        upd_pc         = pc;
        upd_target     = tgt;
        upd_is_jump    = jmp;
        upd_invalidate = inv;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic eh, ej, er, ar;
        logic [AW-1:0] et;
        rst       = 1'b1;
        lookup_pc = '0;
        flush_req = 1'b0;
        drive_upd(1'b0, '0, '0, 1'b0, 1'b0);
        model_reset();
        #3;
        checks++;
        if ({lookup_hit, lookup_is_jump, lookup_target, flush_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: hit=%b jump=%b tgt=%h busy=%b, want all 0",
                     lookup_hit, lookup_is_jump, lookup_target, flush_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        lookup_pc = 32'h0000_1000;
        tick(eh, ej, et, er, ar);
        checks++;
        if ({lookup_hit, lookup_target} !== {1'b0, 32'h0} || lookup_hit !== eh) begin
            errors++;
            $display("FAIL reset_lookup: hit=%b tgt=%h, want hit=0 tgt=0", lookup_hit, lookup_target);
        end
        checks++;
        if (ar !== 1'b1 || ar !== er) begin
            errors++;
            $display("FAIL reset_ready: upd_ready=%b want 1", ar);
        end
        checks++;
        if (flush_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: flush_busy=%b want 0", flush_busy);
        end
    endtask

    task automatic test_install_lookup();
        logic eh, ej, er, ar;
        logic [AW-1:0] et;
        drive_upd(1'b1, 32'h0000_1004, 32'h0000_2000, 1'b1, 1'b0);
        lookup_pc = 32'h0000_0040;
        tick(eh, ej, et, er, ar);
        checks++;
        if (ar !== 1'b1) begin
            errors++;
            $display("FAIL install_accept: upd_ready=%b want 1", ar);
        end
        drive_upd(1'b0, '0, '0, 1'b0, 1'b0);
        lookup_pc = 32'h0000_1004;
        tick(eh, ej, et, er, ar);
        checks++;
        if ({lookup_hit, lookup_is_jump, lookup_target} !== {1'b1, 1'b1, 32'h0000_2000}
            || {lookup_hit, lookup_is_jump, lookup_target} !== {eh, ej, et}) begin
            errors++;
            $display("FAIL install_hit: hit=%b jump=%b tgt=%h want 1 1 00002000",
                     lookup_hit, lookup_is_jump, lookup_target);
        end
        lookup_pc = 32'h0000_2004;
        tick(eh, ej, et, er, ar);
        checks++;
        if ({lookup_hit, lookup_is_jump, lookup_target} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL tag_miss: hit=%b jump=%b tgt=%h want 0 0 0",
                     lookup_hit, lookup_is_jump, lookup_target);
        end
    endtask

    task automatic test_read_before_write();
        logic eh, ej, er, ar;
        logic [AW-1:0] et;
        drive_upd(1'b1, 32'h0000_3008, 32'h0000_4444, 1'b0, 1'b0);
        lookup_pc = 32'h0000_3008;
        tick(eh, ej, et, er, ar);
        checks++;
        if (lookup_hit !== 1'b0 || lookup_hit !== eh) begin
            errors++;
            $display("FAIL rbw_same_edge: hit=%b want 0", lookup_hit);
        end
        drive_upd(1'b0, '0, '0, 1'b0, 1'b0);
        tick(eh, ej, et, er, ar);
        checks++;
        if ({lookup_hit, lookup_is_jump, lookup_target} !== {1'b1, 1'b0, 32'h0000_4444}) begin
            errors++;
            $display("FAIL rbw_next_edge: hit=%b jump=%b tgt=%h want 1 0 00004444",
                     lookup_hit, lookup_is_jump, lookup_target);
        end
    endtask

    task automatic test_invalidate();
        logic eh, ej, er, ar;
        logic [AW-1:0] et;
        drive_upd(1'b1, 32'h0000_2004, '0, 1'b0, 1'b1);
        lookup_pc = 32'h0000_1004;
        tick(eh, ej, et, er, ar);
        drive_upd(1'b0, '0, '0, 1'b0, 1'b0);
        tick(eh, ej, et, er, ar);
        checks++;
        if ({lookup_hit, lookup_target} !== {1'b1, 32'h0000_2000}) begin
            errors++;
            $display("FAIL inv_mismatch: hit=%b tgt=%h want 1 00002000", lookup_hit, lookup_target);
        end
        drive_upd(1'b1, 32'h0000_1004, '0, 1'b0, 1'b1);
        tick(eh, ej, et, er, ar);
        drive_upd(1'b0, '0, '0, 1'b0, 1'b0);
        tick(eh, ej, et, er, ar);
        checks++;
        if ({lookup_hit, lookup_is_jump, lookup_target} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL inv_match: hit=%b jump=%b tgt=%h want 0 0 0",
                     lookup_hit, lookup_is_jump, lookup_target);
        end
    endtask

    task automatic test_flush_with_update();
        logic eh, ej, er, ar;
        logic [AW-1:0] et;
        logic [AW-1:0] pcs [4];
        int ready_low, busy_cnt, cyc;
        pcs[0] = 32'h0000_0100; pcs[1] = 32'h0000_0204;
        pcs[2] = 32'h0000_0308; pcs[3] = 32'h0000_040C;
        for (int i = 0; i < 4; i++) begin
            drive_upd(1'b1, pcs[i], 32'h0000_A000 + i * 16, i[0], 1'b0);
            tick(eh, ej, et, er, ar);
        end
        drive_upd(1'b1, 32'h0000_5010, 32'h0000_BEE0, 1'b1, 1'b0);
        flush_req = 1'b1;
        ready_low = 0;
        busy_cnt  = 0;
        ar        = 1'b0;
        for (cyc = 0; cyc < 200 && ar !== 1'b1; cyc++) begin
            lookup_pc = pcs[$urandom_range(0, 3)];
            tick(eh, ej, et, er, ar);
            flush_req = 1'b0;
            if (ar !== 1'b1) ready_low++;
            if (flush_busy === 1'b1) busy_cnt++;
            checks++;
            if ({lookup_hit, lookup_is_jump, lookup_target, flush_busy} !== {eh, ej, et, (fl_left > 0)}) begin
                errors++;
                $display("FAIL flush_cycle%0d: hit=%b tgt=%h busy=%b want hit=%b tgt=%h busy=%b",
                         cyc, lookup_hit, lookup_target, flush_busy, eh, et, (fl_left > 0));
            end
        end
        drive_upd(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (ready_low != 65 || ar !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready_low: cycles=%0d accepted=%b want 65 and 1", ready_low, ar);
        end
        checks++;
        if (busy_cnt != 64) begin
            errors++;
            $display("FAIL flush_busy_len: cycles=%0d want 64", busy_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            lookup_pc = pcs[i];
            tick(eh, ej, et, er, ar);
            checks++;
            if (lookup_hit !== 1'b0 || lookup_hit !== eh) begin
                errors++;
                $display("FAIL flush_cleared%0d: hit=%b want 0", i, lookup_hit);
            end
        end
        lookup_pc = 32'h0000_5010;
        tick(eh, ej, et, er, ar);
        checks++;
        if ({lookup_hit, lookup_is_jump, lookup_target} !== {1'b1, 1'b1, 32'h0000_BEE0}) begin
            errors++;
            $display("FAIL flush_held_upd: hit=%b jump=%b tgt=%h want 1 1 0000bee0",
                     lookup_hit, lookup_is_jump, lookup_target);
        end
    endtask

    task automatic test_reset_mid_flush();
        logic eh, ej, er, ar;
        logic [AW-1:0] et;
        drive_upd(1'b1, 32'h0000_6000, 32'h0000_1234, 1'b0, 1'b0);
        tick(eh, ej, et, er, ar);
        drive_upd(1'b0, '0, '0, 1'b0, 1'b0);
        flush_req = 1'b1;
        tick(eh, ej, et, er, ar);
        flush_req = 1'b0;
        for (int i = 0; i < 20; i++) tick(eh, ej, et, er, ar);
        checks++;
        if (flush_busy !== 1'b1) begin
            errors++;
            $display("FAIL midflush_busy: flush_busy=%b want 1", flush_busy);
        end
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if ({flush_busy, lookup_hit} !== 2'b00) begin
            errors++;
            $display("FAIL midflush_async: busy=%b hit=%b want 0 0", flush_busy, lookup_hit);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive_upd(1'b1, 32'h0000_7014, 32'h0000_7777, 1'b1, 1'b0);
        tick(eh, ej, et, er, ar);
        drive_upd(1'b0, '0, '0, 1'b0, 1'b0);
        lookup_pc = 32'h0000_7014;
        tick(eh, ej, et, er, ar);
        checks++;
        if ({lookup_hit, lookup_is_jump, lookup_target, flush_busy} !== {1'b1, 1'b1, 32'h0000_7777, 1'b0}) begin
            errors++;
            $display("FAIL postreset_install: hit=%b jump=%b tgt=%h busy=%b want 1 1 00007777 0",
                     lookup_hit, lookup_is_jump, lookup_target, flush_busy);
        end
        for (int i = 0; i <= N; i++) begin
            lookup_pc = (i == N) ? 32'h0000_6000 : AW'(i << 2);
            tick(eh, ej, et, er, ar);
            checks++;
            if (lookup_hit !== 1'b0 || lookup_hit !== eh) begin
                errors++;
                $display("FAIL postreset_miss pc=%h: hit=%b want 0", lookup_pc, lookup_hit);
            end
        end
    endtask

    task automatic test_random();
        logic eh, ej, er, ar;
        logic [AW-1:0] et;
        logic [AW-1:0] pc;
        ar = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!(upd_valid && ar !== 1'b1)) begin
                pc = (AW'($urandom_range(0, 2)) << (IW + 2)) | AW'($urandom_range(0, 7) << 2)
                     | AW'($urandom_range(0, 3));
                drive_upd(($urandom_range(0, 2) != 0), pc, AW'($urandom),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            end
            lookup_pc = (AW'($urandom_range(0, 2)) << (IW + 2)) | AW'($urandom_range(0, 7) << 2)
                        | AW'($urandom_range(0, 3));
            flush_req = ($urandom_range(0, 149) == 0);
            tick(eh, ej, et, er, ar);
            checks++;
            if ({lookup_hit, lookup_is_jump, lookup_target} !== {eh, ej, et}) begin
                errors++;
                $display("FAIL rand_lookup%0d pc=%h: got %b %b %h want %b %b %h", cyc, lookup_pc,
                         lookup_hit, lookup_is_jump, lookup_target, eh, ej, et);
            end
            checks++;
            if (ar !== er || flush_busy !== (fl_left > 0)) begin
                errors++;
                $display("FAIL rand_ctrl%0d: ready=%b busy=%b want ready=%b busy=%b",
                         cyc, ar, flush_busy, er, (fl_left > 0));
            end
        end
        flush_req = 1'b0;
        drive_upd(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_install_lookup();
        test_read_before_write();
        test_invalidate();
        test_flush_with_update();
        test_reset_mid_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
